stream_512_to_64: RTL and testbench
===================================

STREAM_512_TO_64 -- requirements
Module: stream_512_to_64

Interface
REQ-001 Parameter IN_W, default 512: width of the word popped from the upstream FWFT FIFO.
REQ-002 Parameter OUT_W, default 64: width of each output beat; IN_W SHALL be an integer multiple of OUT_W.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 fifo_dout  input  IN_W  head word of the upstream first-word-fall-through (FWFT) FIFO.
REQ-006 fifo_valid  input  1  fifo_dout holds a valid word.
REQ-007 fifo_rd_en  output  1  pops the FIFO head this cycle.
REQ-008 m_data  output  OUT_W  output beat.
REQ-009 m_valid  output  1  m_data is valid.
REQ-010 m_ready  input  1  downstream accepts the beat.
REQ-011 m_last  output  1  high on the final beat of each IN_W word.
REQ-012 words_done  output  32  count of IN_W words fully emitted.

Function
REQ-013 Each IN_W word SHALL be emitted as N = IN_W/OUT_W beats, least-significant slice first: beat k = word[k*OUT_W +: OUT_W].
REQ-014 States: EMPTY (no word held) and HOLD (word held in the shift register; beat index idx from 0 to N-1).
REQ-015 fifo_rd_en = fifo_valid && (state==EMPTY || (state==HOLD && idx==N-1 && m_ready)); the signal is combinational, and a pop loads fifo_dout into the shift register on the same edge.
REQ-016 EMPTY->HOLD on a pop; idx<=0.
REQ-017 HOLD with m_ready && idx<N-1: shift the register right by OUT_W and increment idx.
REQ-018 HOLD with m_ready && idx==N-1: words_done increments; go to HOLD with idx<=0 if a pop occurs that cycle, else go to EMPTY.
REQ-019 HOLD with !m_ready: m_data, m_last and idx hold; no pop.
REQ-020 m_valid = (state==HOLD); m_data = shift register [OUT_W-1:0]; m_last = (state==HOLD && idx==N-1).
REQ-021 Latency: a word first valid at fifo_dout in cycle T while EMPTY SHALL give beat 0 on m_data in cycle T+1.
REQ-022 Throughput: with m_ready held high and fifo_valid held high, m_valid SHALL stay high with no bubble between words (one beat per cycle).
REQ-023 m_data and m_valid SHALL NOT change while m_valid && !m_ready.
REQ-024 words_done SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 fifo_valid deasserting while HOLD SHALL have no effect on the word being emitted.

Reset
REQ-026 While reset_n=0: state=EMPTY, idx=0, shift register=0, words_done=0; m_valid=0, m_last=0, m_data=0, fifo_rd_en=0.
REQ-027 Reset mid-word SHALL discard the remaining beats; after release, emission restarts with beat 0 of the next FIFO word.
REQ-028 The first pop SHALL occur no earlier than the first rising edge after reset_n rises.

Structure
REQ-029 IN_W and OUT_W defaults, N, and the index width $clog2(N) SHALL live in the shared wordcount package.
REQ-030 The block SHALL be flat, with no sub-module; the counter and the shift register are inline.

Verification
REQ-031 Reset release, fifo_valid=1, fifo_dout=0x3F..0x00 byte ramp, m_ready=1 -> one pop; 8 beats 0x0706050403020100 ... 0x3F3E3D3C3B3A3938; m_last on beat 8 only; words_done=1.
REQ-032 Three words queued, m_ready=1 -> 24 consecutive m_valid cycles; pops on cycles 0, 8 and 16 only; words_done=3.
REQ-033 m_ready=0 for 5 cycles at beat 3 -> m_data and m_last stable; no pop; beat 4 follows when m_ready returns.
REQ-034 Assert reset_n=0 at beat 5 of word A, with word B queued -> outputs zero during reset; first beat after release is B beat 0; words_done=0.
REQ-035 Preload words_done to 0xFFFFFFFF via hierarchical force, then emit one word -> words_done=0.
REQ-036 Random fifo_valid and m_ready over 10k cycles -> scoreboard output matches input order; no beat lost or duplicated; fifo_rd_en never high when fifo_valid=0.

Source files
------------

// File: rtl/stream_512_to_64_pkg.sv
// Shared definitions for the wide-to-narrow stream splitter: default word
// widths, beat-count / index-width helpers and the controller state encoding.
package stream_512_to_64_pkg;

    localparam int IN_W_DEF  = 512;
    localparam int OUT_W_DEF = 64;

    // Beats per input word and the width of the beat index register.
    function automatic int beats_per_word(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_DEF     = IN_W_DEF / OUT_W_DEF;
    localparam int IDX_W_DEF = (N_DEF > 1) ? $clog2(N_DEF) : 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/stream_512_to_64.sv
// Splits IN_W-bit words popped from a first-word-fall-through FIFO into
// OUT_W-bit beats, least-significant slice first, with valid/ready output
// handshake and a running count of fully emitted words.
//
// state    | meaning
// ST_EMPTY | no word held; pop the FIFO head as soon as it is valid
// ST_HOLD  | word held in r_shift; r_idx is the beat currently on m_data
//
// IN_W must be an integer multiple of OUT_W.
module stream_512_to_64
    import stream_512_to_64_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  fifo_dout,
    input  logic             fifo_valid,
    output logic             fifo_rd_en,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [31:0]      words_done
);

    localparam int N     = beats_per_word(IN_W, OUT_W);
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run;
    logic [IN_W-1:0]    r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_words_done;

    logic               w_last_idx;
    logic               w_beat_take;
    logic               w_word_done;
    logic               w_pop;

    assign w_last_idx  = (r_idx == IDX_LAST);
    assign w_beat_take = (r_state == ST_HOLD) && m_ready;
    assign w_word_done = w_beat_take && w_last_idx;

    // r_run keeps the pop request low through reset and until the first edge
    // after release, so a word is never taken while reset is still settling.
    assign w_pop = fifo_valid && r_run &&
                   ((r_state == ST_EMPTY) || w_word_done);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: enter HOLD on a pop, leave it only after the last
    // beat is accepted with no follow-on word available.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_pop) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_word_done && !w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs derived from state and beat index.
    always_comb begin
        m_valid    = 1'b0;
        m_last     = 1'b0;
        fifo_rd_en = w_pop;
        if (r_state == ST_HOLD) begin
            m_valid = 1'b1;
            m_last  = w_last_idx;
        end
    end

    // Shift register and beat index: load on pop, shift one slice per
    // accepted beat, freeze while the downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run   <= 1'b0;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_pop) begin
                r_shift <= fifo_dout;
                r_idx   <= '0;
            end else if (w_word_done) begin
                r_shift <= r_shift >> OUT_W;
                r_idx   <= '0;
            end else if (w_beat_take) begin
                r_shift <= r_shift >> OUT_W;
                r_idx   <= r_idx + IDX_ONE;
            end
        end
    end

    // Completed-word counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_words_done <= '0;
        end else if (w_word_done) begin
            r_words_done <= r_words_done + 32'd1;
        end
    end

    assign m_data     = r_shift[OUT_W-1:0];
    assign words_done = r_words_done;

endmodule

// File: tb/tb_stream_512_to_64.sv
// Scoreboard bench for stream_512_to_64: the driver models the FWFT FIFO and
// pushes expected beats when a word is queued; a negedge monitor pops and
// compares each accepted beat.
module tb_stream_512_to_64;
    import stream_512_to_64_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [511:0] fifo_dout;
    logic         fifo_valid;
    logic         fifo_rd_en;
    logic [63:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic [31:0]  words_done;

    beat_t        exp_q[$];
    logic [511:0] fifo_q[$];
    int           pop_log[$];
    bit           fifo_en;
    bit           pop_pending = 1'b0;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           pop_cnt = 0;

    logic         prev_stall = 1'b0;
    logic [63:0]  prev_data = '0;
    logic         prev_last = 1'b0;

    always #5 clk = ~clk;

    stream_512_to_64 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_dout  (fifo_dout),
        .fifo_valid (fifo_valid),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .words_done (words_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] ramp(input logic [7:0] base);
        logic [511:0] w;
        for (int i = 0; i < 64; i++) w[i*8 +: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic refresh();
        fifo_valid = fifo_en && (fifo_q.size() > 0);
        fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [511:0] w);
        beat_t b;
        fifo_q.push_back(w);
        for (int k = 0; k < N; k++) begin
            b.d = w[k*64 +: 64];
            b.l = (k == N - 1);
            exp_q.push_back(b);
        end
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pop_pending) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
            pop_log.push_back(cyc);
        end
        refresh();
    endtask

    task automatic drain(input int budget);
        m_ready = 1'b1;
        fifo_en = 1'b1;
        refresh();
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) pop_pending <= fifo_rd_en;

    // Monitor: compares every accepted beat and checks stall stability.
    always @(negedge clk) begin
        beat_t e;
        if (reset_n) begin
            chk("rd_en_gate", 64'(fifo_rd_en & ~fifo_valid), 64'd0);
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_data, 64'hx);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_last", 64'(m_last), 64'(e.l));
                end
            end
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int run;
        int pc;
        int nw;
        logic [31:0] wd0;
        logic [511:0] w;

        m_ready = 1'b1;
        fifo_en = 1'b1;
        reset_n = 1'b0;
        refresh();

        // Reset state with a word already waiting.
        push_word(ramp(8'h00));
        repeat (3) tick();
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_words_done", 64'(words_done), 64'd0);

        // Byte ramp word: 8 beats, last on beat 8, one pop.
        reset_n = 1'b1;
        for (int i = 0; i < 10 && !m_valid; i++) tick();
        chk("t1_valid", 64'(m_valid), 64'd1);
        chk("t1_beat0", m_data, 64'h0706050403020100);
        chk("t1_beat0_last", 64'(m_last), 64'd0);
        n = 0;
        for (int i = 0; i < 10 && !m_last; i++) begin
            tick();
            n++;
        end
        chk("t1_beats_to_last", 64'(n), 64'd7);
        chk("t1_beat7", m_data, 64'h3F3E3D3C3B3A3938);
        tick();
        chk("t1_words_done", 64'(words_done), 64'd1);
        chk("t1_pops", 64'(pop_cnt), 64'd1);
        chk("t1_idle", 64'(m_valid), 64'd0);

        // Three back-to-back words: latency 1, 24 valid cycles, pops every 8.
        pop_log.delete();
        wd0 = words_done;
        push_word(ramp(8'h10));
        push_word(ramp(8'h55));
        push_word({16{32'hDEADBEEF}});
        tick();
        chk("t2_latency", 64'(m_valid), 64'd1);
        chk("t2_beat0", m_data, 64'h1716151413121110);
        run = m_valid ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m_valid) run++;
            else break;
        end
        chk("t2_valid_run", 64'(run), 64'd24);
        chk("t2_pop_count", 64'(pop_log.size()), 64'd3);
        if (pop_log.size() == 3) begin
            chk("t2_pop1_gap", 64'(pop_log[1] - pop_log[0]), 64'd8);
            chk("t2_pop2_gap", 64'(pop_log[2] - pop_log[0]), 64'd16);
        end
        chk("t2_words_done", 64'(words_done - wd0), 64'd3);

        // Stall at beat 3 for five cycles with a second word queued.
        push_word(ramp(8'h40));
        for (int i = 0; i < 10 && !m_valid; i++) tick();
        repeat (3) tick();
        chk("t3_beat3", m_data, 64'h5F5E5D5C5B5A5958);
        m_ready = 1'b0;
        pc = pop_cnt;
        push_word(ramp(8'h00));
        repeat (5) tick();
        chk("t3_stall_beat3", m_data, 64'h5F5E5D5C5B5A5958);
        chk("t3_stall_last", 64'(m_last), 64'd0);
        chk("t3_stall_nopop", 64'(pop_cnt - pc), 64'd0);
        m_ready = 1'b1;
        tick();
        chk("t3_beat4", m_data, 64'h6766656463626160);
        drain(100);

        // Reset at beat 5 of word A with word B queued.
        push_word(ramp(8'h80));
        push_word(ramp(8'hC0));
        for (int i = 0; i < 10 && !m_valid; i++) tick();
        repeat (5) tick();
        chk("t4_beat5", m_data, 64'h AFAEADACABAAA9A8);
        reset_n = 1'b0;
        n = exp_q.size() - fifo_q.size() * N;
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
        repeat (2) tick();
        chk("t4_rst_valid", 64'(m_valid), 64'd0);
        chk("t4_rst_data", m_data, 64'd0);
        chk("t4_rst_last", 64'(m_last), 64'd0);
        chk("t4_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("t4_rst_words_done", 64'(words_done), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10 && !m_valid; i++) tick();
        chk("t4_b_beat0", m_data, 64'hC7C6C5C4C3C2C1C0);
        chk("t4_words_done_b0", 64'(words_done), 64'd0);
        drain(100);
        chk("t4_words_done_end", 64'(words_done), 64'd1);

        // Counter wrap.
        force dut.r_words_done = 32'hFFFF_FFFF;
        tick();
        release dut.r_words_done;
        tick();
        chk("t5_preload", 64'(words_done), 64'hFFFF_FFFF);
        push_word(ramp(8'h21));
        drain(100);
        chk("t5_wrap", 64'(words_done), 64'd0);

        // Random fifo_valid / m_ready traffic.
        wd0 = words_done;
        nw = 0;
        for (int c = 0; c < 10000; c++) begin
            fifo_en = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 1) != 0);
            if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 16; j++) w[j*32 +: 32] = $urandom;
                push_word(w);
                nw++;
            end
            refresh();
            tick();
        end
        drain(1000);
        chk("t6_words_done", 64'(words_done - wd0), 64'(nw));
        chk("t6_fifo_empty", 64'(fifo_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
